// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: load/store opcodes and the
// bus-master state type.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } mem_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_lane_decoder.sv
// Combinational lane decoder: maps opcode and the low address bits to the
// little-endian byte enables and lane-replicated store data.
module mem_lane_decoder
  import mips_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rt,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  output logic        o_is_load,
  output logic        o_is_store
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    o_byteenable = 4'b1111;
    o_writedata  = i_rt;
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    unique case (i_op)
      OP_LB, OP_LBU: begin
        o_byteenable = 4'b0001 << i_addr_lo;
        o_is_load    = 1'b1;
      end
      OP_SB: begin
        o_byteenable = 4'b0001 << i_addr_lo;
        o_writedata  = {4{i_rt[7:0]}};
        o_is_store   = 1'b1;
      end
      OP_LH, OP_LHU: begin
        o_byteenable = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_is_load    = 1'b1;
      end
      OP_SH: begin
        o_byteenable = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_writedata  = {2{i_rt[15:0]}};
        o_is_store   = 1'b1;
      end
      OP_LW:  o_is_load  = 1'b1;
      OP_SW:  o_is_store = 1'b1;
      OP_LWL: begin
        o_is_load = 1'b1;
        unique case (i_addr_lo)
          2'd0:    o_byteenable = 4'b0001;
          2'd1:    o_byteenable = 4'b0011;
          2'd2:    o_byteenable = 4'b0111;
          default: o_byteenable = 4'b1111;
        endcase
      end
      OP_LWR: begin
        o_is_load = 1'b1;
        unique case (i_addr_lo)
          2'd0:    o_byteenable = 4'b1111;
          2'd1:    o_byteenable = 4'b1110;
          2'd2:    o_byteenable = 4'b1100;
          default: o_byteenable = 4'b1000;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// MEM-stage Avalon-MM master: one bus access per load/store, pipeline stall
// while the access is outstanding, sticky watchdog on a hung slave.
module memory_access_unit
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_memory,
  input  logic        mem_write_memory,
  input  logic [5:0]  op_memory,
  input  logic [31:0] ALU_output_memory,
  input  logic [31:0] write_data_memory,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] read_data_memory,
  output logic [3:0]  byteenable_memory,
  output logic        stall_memory,
  output logic        bus_error
);

  localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  mem_state_t        r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_bus_error;
  logic [31:0]       r_avm_address;
  logic              r_avm_read;
  logic              r_avm_write;
  logic [31:0]       r_avm_writedata;
  logic [3:0]        r_avm_byteenable;
  logic [31:0]       r_read_data;
  logic [3:0]        r_byteenable;

  logic              w_req;
  logic [3:0]        w_lane_be;
  logic [31:0]       w_lane_wdata;
  logic              w_is_load;
  logic              w_is_store;

  assign w_req = mem_read_memory | mem_write_memory;

  mem_lane_decoder u_lane_decoder (
    .i_op         (op_memory),
    .i_addr_lo    (ALU_output_memory[1:0]),
    .i_rt         (write_data_memory),
    .o_byteenable (w_lane_be),
    .o_writedata  (w_lane_wdata),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store)
  );

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // clears every register, so an in-flight request drops the instant reset falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_wait_cnt       <= '0;
      r_bus_error      <= 1'b0;
      r_avm_address    <= '0;
      r_avm_read       <= 1'b0;
      r_avm_write      <= 1'b0;
      r_avm_writedata  <= '0;
      r_avm_byteenable <= '0;
      r_read_data      <= '0;
      r_byteenable     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // A tripped watchdog blocks all further traffic until reset.
          if (w_req && !r_bus_error) begin
            r_avm_address    <= word_align(ALU_output_memory);
            r_avm_write      <= mem_write_memory;
            r_avm_read       <= mem_read_memory & ~mem_write_memory;
            r_avm_writedata  <= w_is_store ? w_lane_wdata : '0;
            r_avm_byteenable <= (w_is_load | w_is_store) ? w_lane_be : '0;
            r_wait_cnt       <= '0;
            r_state          <= ISSUE;
          end else begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
          end
        end
        ISSUE: begin
          if (avm_waitrequest) begin
            if (r_wait_cnt == WAIT_LAST) begin
              r_bus_error <= 1'b1;
              r_avm_read  <= 1'b0;
              r_avm_write <= 1'b0;
              r_wait_cnt  <= '0;
              r_state     <= IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end else begin
            r_read_data  <= r_avm_read ? avm_readdata : '0;
            r_byteenable <= r_avm_byteenable;
            r_avm_read   <= 1'b0;
            r_avm_write  <= 1'b0;
            r_wait_cnt   <= '0;
            r_state      <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // DONE is the one cycle in which EX/MEM still holds the finished instruction
  // but the pipeline is allowed to advance past it.
  assign stall_memory = ((r_state == IDLE) && w_req) || (r_state == ISSUE) || r_bus_error;

  assign avm_address       = r_avm_address;
  assign avm_read          = r_avm_read;
  assign avm_write         = r_avm_write;
  assign avm_writedata     = r_avm_writedata;
  assign avm_byteenable    = r_avm_byteenable;
  assign read_data_memory  = r_read_data;
  assign byteenable_memory = r_byteenable;
  assign bus_error         = r_bus_error;

endmodule
